// File: rtl/dec_pkg.sv
// Shared constants and FSM state type for the dec_scan decoder/scanner.
// Defaults here match the 3-to-8 build with a prescale of 4.
package dec_pkg;

  localparam int DEF_N   = 3;
  localparam int DEF_DIV = 4;
  localparam int DEF_NF  = 3;

  // f0={0,5,7}, f1={2,3,4}, f2={1,6,7}
  localparam logic [23:0] DEF_FN_MASK = 24'hC21CA1;

  typedef enum logic [1:0] {
    IDLE,
    DIRECT,
    SCAN
  } state_t;

endpackage

// File: rtl/dec_onehot.sv
// Combinational N-to-2^N one-hot decoder with enable.
// Output is all-zero while en is low.
module dec_onehot #(
  parameter int N = 3
) (
  input  logic [N-1:0]      code,
  input  logic              en,
  output logic [(1<<N)-1:0] y
);

  always_comb begin
    y = '0;
    if (en) y[code] = 1'b1;
  end

endmodule

// File: rtl/dec_scan.sv
// One-hot decoder with direct/scan modes, prescaled scan and minterm outputs.
// Define DEC_SCAN_FN_EN to build the FN_MASK minterm logic; otherwise f is 0.
module dec_scan
  import dec_pkg::*;
#(
  parameter int N   = DEF_N,
  parameter int DIV = DEF_DIV,
  parameter int NF  = DEF_NF,
  parameter logic [NF*(1<<N)-1:0] FN_MASK = DEF_FN_MASK
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic              mode,
  input  logic [N-1:0]      w,
  output logic [(1<<N)-1:0] y,
  output logic [N-1:0]      idx,
  output logic              wrap,
  output logic [NF-1:0]     f
);

  localparam int M  = 1 << N;
  localparam int PW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [PW-1:0] PLAST = PW'(DIV - 1);

  if ($bits(FN_MASK) != NF * M || DIV < 1 || DIV > 256) begin : g_bad_cfg
    $error("dec_scan: bad parameter set");
  end

  state_t          state;
  state_t          state_nx;
  logic [N-1:0]    idx_nx;
  logic [PW-1:0]   psc;
  logic [PW-1:0]   psc_nx;
  logic            act;
  logic            act_nx;
  logic            wrap_nx;
  logic [M-1:0]    y_nx;

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = IDLE;
    unique case (1'b1)
      !en:          state_nx = IDLE;
      en && !mode:  state_nx = DIRECT;
      en && mode:   state_nx = SCAN;
      default:      state_nx = IDLE;
    endcase
  end

  // act marks a scan that was suspended by en=0 and must resume, not restart
  always_comb begin
    idx_nx  = idx;
    psc_nx  = psc;
    act_nx  = act;
    wrap_nx = 1'b0;
    unique case (state_nx)
      DIRECT: begin
        idx_nx = w;
        psc_nx = '0;
        act_nx = 1'b0;
      end
      SCAN: begin
        act_nx = 1'b1;
        if (state != SCAN) begin
          if (!act) begin
            idx_nx = '0;
            psc_nx = '0;
          end
        end else if (psc == PLAST) begin
          idx_nx  = idx + 1'b1;
          psc_nx  = '0;
          wrap_nx = (idx == '1);
        end else begin
          psc_nx = psc + 1'b1;
        end
      end
      default: ;
    endcase
  end

  dec_onehot #(.N(N)) u_dec (
    .code (idx_nx),
    .en   (state_nx != IDLE),
    .y    (y_nx)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      y    <= '0;
      idx  <= '0;
      psc  <= '0;
      act  <= 1'b0;
      wrap <= 1'b0;
    end else begin
      y    <= y_nx;
      idx  <= idx_nx;
      psc  <= psc_nx;
      act  <= act_nx;
      wrap <= wrap_nx;
    end
  end

`ifdef DEC_SCAN_FN_EN
  logic [NF-1:0] f_nx;

  always_comb begin
    f_nx = '0;
    for (int k = 0; k < NF; k++)
      f_nx[k] = |(y_nx & FN_MASK[k*M +: M]);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) f <= '0;
    else        f <= f_nx;
  end
`else
  assign f = '0;
`endif

endmodule

// File: tb/tb_dec_scan.sv
// Directed bench for dec_scan: DIV=4 instance for modes/freeze/reset,
// DIV=1 instance for single-cycle stepping.
module tb_dec_scan;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       en, mode, en1, mode1;
  logic [2:0] w, w1;
  logic [7:0] y, y1;
  logic [2:0] idx, idx1;
  logic       wrap, wrap1;
  logic [2:0] f, f1;

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  dec_scan #(.DIV(4)) u_dut (
    .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .w(w),
    .y(y), .idx(idx), .wrap(wrap), .f(f)
  );

  dec_scan #(.DIV(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .en(en1), .mode(mode1), .w(w1),
    .y(y1), .idx(idx1), .wrap(wrap1), .f(f1)
  );

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // minterm table: f0={0,5,7}, f1={2,3,4}, f2={1,6,7}
  function automatic logic [31:0] fx(input int m);
`ifdef DEC_SCAN_FN_EN
    case (m)
      0: return 32'b001;
      1: return 32'b100;
      2: return 32'b010;
      3: return 32'b010;
      4: return 32'b010;
      5: return 32'b001;
      6: return 32'b100;
      default: return 32'b101;
    endcase
`else
    return (m < 0) ? 32'd1 : 32'd0;
`endif
  endfunction

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; en = 1'b0; mode = 1'b0; w = 3'd0;
    en1 = 1'b0; mode1 = 1'b0; w1 = 3'd0;
    step(2);
    chk("rst_y", y, 0);
    chk("rst_idx", idx, 0);
    chk("rst_wrap", wrap, 0);
    chk("rst_f", f, 0);

    rst_n = 1'b1; en = 1'b1; w = 3'd5;
    step(1);
    chk("dir5_y", y, 32'h20);
    chk("dir5_idx", idx, 5);
    chk("dir5_f", f, fx(5));
    chk("dir5_wrap", wrap, 0);
    w = 3'd3;
    step(1);
    chk("dir3_y", y, 32'h08);
    chk("dir3_f", f, fx(3));

    en = 1'b0;
    step(1);
    chk("idle_y", y, 0);
    en = 1'b1; mode = 1'b1;
    step(1);
    chk("scan0_y", y, 32'h01);
    chk("scan0_idx", idx, 0);
    for (int i = 1; i <= 32; i++) begin
      step(1);
      chk("scan_idx", idx, 32'((i / 4) % 8));
      chk("scan_y", y, 32'(1) << ((i / 4) % 8));
      chk("scan_wrap", wrap, (i == 32) ? 1 : 0);
    end

    step(26);
    chk("pre_frz_idx", idx, 6);
    en = 1'b0;
    step(10);
    chk("frz_y", y, 0);
    chk("frz_f", f, 0);
    chk("frz_idx", idx, 6);
    en = 1'b1;
    step(1);
    chk("resume_y", y, 32'h40);
    chk("resume_f", f, fx(6));
    step(1);
    chk("resume_hold", idx, 6);
    step(1);
    chk("resume_step", y, 32'h80);

    step(4);
    chk("wrap2_idx", idx, 0);
    chk("wrap2_pulse", wrap, 1);
    step(8);
    chk("at2_idx", idx, 2);
    chk("at2_wrap", wrap, 0);
    mode = 1'b0; w = 3'd7;
    step(1);
    chk("sw_dir_y", y, 32'h80);
    chk("sw_dir_f", f, fx(7));
    chk("sw_dir_wrap", wrap, 0);
    mode = 1'b1;
    step(1);
    chk("sw_scan_y", y, 32'h01);
    chk("sw_scan_wrap", wrap, 0);

    step(31);
    chk("pre_rst_idx", idx, 7);
    rst_n = 1'b0;
    step(1);
    chk("mrst_y", y, 0);
    chk("mrst_idx", idx, 0);
    chk("mrst_wrap", wrap, 0);
    chk("mrst_f", f, 0);
    rst_n = 1'b1;
    step(1);
    chk("post_rst_y", y, 32'h01);
    chk("post_rst_wrap", wrap, 0);
    step(4);
    chk("post_rst_idx", idx, 1);

    en1 = 1'b1; mode1 = 1'b1;
    step(1);
    chk("d1_y0", y1, 32'h01);
    for (int i = 1; i <= 16; i++) begin
      step(1);
      chk("d1_idx", idx1, 32'(i % 8));
      chk("d1_y", y1, 32'(1) << (i % 8));
      chk("d1_wrap", wrap1, (i % 8 == 0) ? 1 : 0);
      chk("d1_f", f1, fx(i % 8));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/dec_scan.md
DEC_SCAN -- requirements
Module: dec_scan

Interface
REQ-001 Parameter N, default 3: select width; output width 2^N.
REQ-002 Parameter DIV, default 4: scan prescale, 1..256; scan steps once per DIV enabled cycles.
REQ-003 Parameter NF, default 3: number of minterm-function outputs.
REQ-004 Parameter FN_MASK, NF*2^N bits, default 24'hC21CA1: bit k*2^N+m set puts minterm m in function f[k]. The default gives f0={0,5,7}, f1={2,3,4} and f2={1,6,7}.
REQ-005 clk  in  1  sole clock; all state on rising edge.
REQ-006 rst_n  in  1  reset, synchronous, active-low.
REQ-007 en  in  1  enable; low forces outputs to zero and freezes the scan.
REQ-008 mode  in  1  0 = direct decode of w, 1 = autonomous scan.
REQ-009 w  in  N  select code, used only when mode=0.
REQ-010 y  out  2^N  registered one-hot decode; all-zero when disabled.
REQ-011 idx  out  N  registered code currently decoded onto y.
REQ-012 wrap  out  1  one-cycle pulse when the scan steps from 2^N-1 to 0.
REQ-013 f  out  NF  registered minterm functions of the y value.

Function
REQ-014 FSM states: IDLE (en=0), DIRECT (en=1, mode=0), SCAN (en=1, mode=1); the next state is chosen from en and mode every cycle.
REQ-015 DIRECT: y <= onehot(w), idx <= w, prescaler <= 0; latency 1 cycle; wrap=0.
REQ-016 Entry to SCAN from DIRECT or reset-IDLE: idx <= 0, y <= onehot(0), prescaler <= 0.
REQ-017 SCAN: prescaler counts 0..DIV-1. At DIV-1: idx <= idx+1 mod 2^N, y <= onehot(idx+1), prescaler <= 0. Otherwise hold idx and y.
REQ-018 wrap <= 1 only in the cycle y/idx update from 2^N-1 to 0; a mid-scan entry reset to 0 (REQ-016) does not pulse wrap.
REQ-019 DIV=1: step every cycle; idx period is 2^N cycles.
REQ-020 IDLE: y <= 0, f <= 0, wrap <= 0. idx and prescaler hold.
REQ-021 IDLE to SCAN with scan previously active: resume at held idx/prescaler; y <= onehot(idx) next cycle; no restart.
REQ-022 SCAN to DIRECT mid-step: next cycle decodes w; prescaler cleared; wrap=0.
REQ-023 f[k] <= OR over m of (y_next[m] & FN_MASK[k*2^N+m]); same cycle as y; never a cycle behind.
REQ-024 At most one y bit is high in any cycle; idx always equals the encoded y while en=1.

Reset
REQ-025 rst_n=0 at a clock edge: y=0, idx=0, f=0, wrap=0, prescaler=0, state IDLE, scan-active flag cleared; applies mid-scan and overrides en/mode.
REQ-026 First edge with rst_n=1 evaluates en/mode normally; SCAN entry follows REQ-016.

Configuration
REQ-027 Macro DEC_SCAN_FN_EN. Defined: f computed per REQ-023. Undefined: f tied to 0 and no FN_MASK logic synthesised; all other behaviour identical.

Structure
REQ-028 Package dec_pkg holds the default N/DIV/NF/FN_MASK constants and the state enum (IDLE, DIRECT, SCAN).
REQ-029 Sub-module dec_onehot: combinational N-to-2^N decoder with enable; instantiated once for y_next.

Verification
REQ-030 Direct: en=1, mode=0, w=5 -> next cycle y=8'h20, idx=5, f=3'b001; w=3 -> y=8'h08, f=3'b010.
REQ-031 Scan: DIV=4, en=1, mode=1 from IDLE -> y=8'h01; y advances every 4 cycles; after 32 cycles wrap pulses once with y=8'h01.
REQ-032 Freeze: en=0 at idx=6 for 10 cycles -> y=0, f=0. en=1 -> y=8'h40, f=3'b100; the remaining prescale count is preserved.
REQ-033 Mode switch: in SCAN at idx=2, mode=0, w=7 -> next cycle y=8'h80, f=3'b101. mode=1 -> y=8'h01, no wrap.
REQ-034 Reset mid-scan at idx=7 with prescaler=3: rst_n=0 one edge -> all outputs 0. There is no wrap pulse, and the restart is at idx 0.
REQ-035 DIV=1 with DEC_SCAN_FN_EN undefined: y steps every cycle, wrap every 8 cycles, f constantly 0.
